// File: rtl/ysyx_22040729_multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding, reset PC,
// the NOP that seeds the instruction latch, and the load writeback source code.
package ysyx_22040729_multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_IWAIT = 3'd1,
    S_EXEC  = 3'd2,
    S_MREQ  = 3'd3,
    S_MWAIT = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  localparam logic [63:0] RESET_PC_DEF   = 64'h8000_0000;
  localparam logic [31:0] NOP_INST       = 32'h0000_0013;
  localparam logic [1:0]  WDATA_SRC_LOAD = 2'b01;

endpackage

// File: rtl/ysyx_22040729_multicycle_ctrl_reg.sv
// Async-reset register primitive with write enable; reset value is a parameter.
module ysyx_22040729_multicycle_ctrl_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= RESET_VAL;
    else if (wen) q <= d;
  end

endmodule

// File: rtl/ysyx_22040729_multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH -> IWAIT -> EXEC [-> MREQ -> MWAIT] -> FETCH.
// Owns PC and the instruction latch; qualifies rf_we so each instruction writes once.
module ysyx_22040729_multicycle_ctrl
  import ysyx_22040729_multicycle_ctrl_pkg::*;
#(
  parameter int                    INST_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  input  logic                  ifu_rsp_valid,
  input  logic [INST_WIDTH-1:0] ifu_rsp_inst,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  dec_rf_we,
  input  logic [1:0]            dec_rf_wdata_src,
  input  logic                  dec_mem_wen,
  input  logic                  dec_ebreak,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  lsu_req_valid,
  input  logic                  lsu_req_ready,
  output logic                  lsu_req_wen,
  input  logic                  lsu_rsp_valid,
  output logic                  rf_we,
  output logic                  inst_retired,
  output logic                  halt
);

  logic [2:0] state_raw_q;
  state_e     state_q;
  state_e     state_d;
  logic       pc_we;
  logic       inst_we;
  logic       is_mem;

  assign state_q = state_e'(state_raw_q);
  assign is_mem  = (dec_rf_wdata_src == WDATA_SRC_LOAD) || dec_mem_wen;

  ysyx_22040729_multicycle_ctrl_reg #(.WIDTH(3), .RESET_VAL(S_FETCH)) u_state_reg (
    .clk(clk), .rst(rst), .wen(1'b1), .d(state_d), .q(state_raw_q)
  );

  ysyx_22040729_multicycle_ctrl_reg #(.WIDTH(ADDR_WIDTH), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk(clk), .rst(rst), .wen(pc_we), .d(next_pc), .q(pc)
  );

  ysyx_22040729_multicycle_ctrl_reg #(.WIDTH(INST_WIDTH), .RESET_VAL(INST_WIDTH'(NOP_INST))) u_inst_reg (
    .clk(clk), .rst(rst), .wen(inst_we), .d(ifu_rsp_inst), .q(inst)
  );

  // Strobes are decoded from the current state so a write can only fire in the retire cycle.
  always_comb begin
    state_d       = state_q;
    pc_we         = 1'b0;
    inst_we       = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rf_we         = 1'b0;
    inst_retired  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) state_d = S_IWAIT;
      end
      S_IWAIT: begin
        if (ifu_rsp_valid) begin
          inst_we = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dec_ebreak) begin
          state_d = S_HALT;
        end else if (is_mem) begin
          state_d = S_MREQ;
        end else begin
          rf_we        = dec_rf_we;
          pc_we        = 1'b1;
          inst_retired = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_MREQ: begin
        lsu_req_valid = 1'b1;
        if (lsu_req_ready) state_d = S_MWAIT;
      end
      S_MWAIT: begin
        if (lsu_rsp_valid) begin
          rf_we        = dec_rf_we;
          pc_we        = 1'b1;
          inst_retired = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign lsu_req_wen = lsu_req_valid & dec_mem_wen;
  assign halt        = (state_q == S_HALT);

endmodule

// File: tb/tb_ysyx_22040729_multicycle_ctrl.sv
// Scoreboard bench: the driver plays IFU/LSU/decoder and queues expected retires
// and LSU requests; a negedge monitor pops and compares them as the DUT presents them.
module tb_ysyx_22040729_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid, ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_inst = 32'h0;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        dec_rf_we = 1'b0, dec_mem_wen = 1'b0, dec_ebreak = 1'b0;
  logic [1:0]  dec_rf_wdata_src = 2'b00;
  logic [63:0] next_pc = 64'h0;
  logic        lsu_req_valid, lsu_req_ready = 1'b0, lsu_req_wen, lsu_rsp_valid = 1'b0;
  logic        rf_we, inst_retired, halt;

  ysyx_22040729_multicycle_ctrl dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
    .inst(inst), .pc(pc),
    .dec_rf_we(dec_rf_we), .dec_rf_wdata_src(dec_rf_wdata_src),
    .dec_mem_wen(dec_mem_wen), .dec_ebreak(dec_ebreak), .next_pc(next_pc),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_wen(lsu_req_wen), .lsu_rsp_valid(lsu_rsp_valid),
    .rf_we(rf_we), .inst_retired(inst_retired), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [63:0] pc; } retire_t;
  retire_t retire_q[$];
  logic    lsu_wen_q[$];

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] tb_pc = 64'h8000_0000;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (inst_retired) begin
        if (retire_q.size() == 0) begin
          check("unexpected_retire", 64'(inst_retired), 64'd0);
        end else begin
          retire_t e;
          e = retire_q.pop_front();
          check("retire_rf_we", 64'(rf_we), 64'(e.we));
          check("retire_pc", pc, e.pc);
          $display("retire pc=0x%0h inst=0x%08h rf_we=%0b (exp %0b)", pc, inst, rf_we, e.we);
        end
      end
      if (rf_we) check("rf_we_only_at_retire", 64'(inst_retired), 64'd1);
      if (lsu_req_valid && lsu_req_ready) begin
        if (lsu_wen_q.size() == 0) begin
          check("unexpected_lsu_req", 64'(lsu_req_valid), 64'd0);
        end else begin
          logic w;
          w = lsu_wen_q.pop_front();
          check("lsu_req_wen", 64'(lsu_req_wen), 64'(w));
          $display("lsu req wen=%0b (exp %0b)", lsu_req_wen, w);
        end
      end
    end
  end

  // One instruction through fetch/exec/mem; abort_mwait stops inside MWAIT without retiring.
  task automatic run(input logic [31:0] ins, input logic we, input logic [1:0] src,
                     input logic mw, input logic eb, input logic [63:0] npc,
                     input int irdly, input int isdly, input int lrdly, input int lsdly,
                     input bit abort_mwait);
    int t;
    bit is_mem;
    is_mem = (src == 2'b01) || mw;
    t = 0;
    while (!ifu_req_valid && t < 50) begin step(); t++; end
    check("ifu_req_valid_fetch", 64'(ifu_req_valid), 64'd1);
    for (int i = 0; i < irdly; i++) begin
      step();
      check("ifu_req_held", 64'(ifu_req_valid), 64'd1);
    end
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    for (int i = 0; i < isdly; i++) step();
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = ins;
    dec_rf_we = we; dec_rf_wdata_src = src; dec_mem_wen = mw; dec_ebreak = eb; next_pc = npc;
    if (!eb && !abort_mwait) retire_q.push_back('{we: we, pc: tb_pc});
    if (!eb && is_mem) lsu_wen_q.push_back(mw);
    step();
    ifu_rsp_valid = 1'b0;
    check("inst_latched", 64'(inst), 64'(ins));
    if (eb) begin
      step();
      return;
    end
    step();
    if (!is_mem) begin
      tb_pc = npc;
      return;
    end
    for (int i = 0; i < lrdly; i++) begin
      check("lsu_req_held", 64'(lsu_req_valid), 64'd1);
      step();
    end
    lsu_req_ready = 1'b1;
    lsu_rsp_valid = 1'b1;
    step();
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0;
    if (abort_mwait) return;
    for (int i = 0; i < lsdly; i++) step();
    lsu_rsp_valid = 1'b1;
    step();
    lsu_rsp_valid = 1'b0;
    tb_pc = npc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_pc", pc, 64'h8000_0000);
    check("rst_inst_nop", 64'(inst), 64'h13);
    check("rst_ifu_req_valid", 64'(ifu_req_valid), 64'd1);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_lsu_req_valid", 64'(lsu_req_valid), 64'd0);
    step();
    rst = 1'b0;

    // ADDI zero-wait, LD with delayed ready/rsp, SD, JAL far, wrap via +4
    run(32'h0050_0093, 1'b1, 2'b00, 1'b0, 1'b0, tb_pc + 64'd4, 0, 0, 0, 0, 1'b0);
    check("pc_after_addi", pc, 64'h8000_0004);
    run(32'h0000_b103, 1'b1, 2'b01, 1'b0, 1'b0, tb_pc + 64'd4, 0, 0, 2, 3, 1'b0);
    check("pc_after_ld", pc, 64'h8000_0008);
    run(32'h0020_b023, 1'b0, 2'b00, 1'b1, 1'b0, tb_pc + 64'd4, 1, 2, 0, 1, 1'b0);
    run(32'h0000_00ef, 1'b1, 2'b10, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 2, 1, 0, 0, 1'b0);
    check("pc_after_jal", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    run(32'h0010_0113, 1'b1, 2'b00, 1'b0, 1'b0, tb_pc + 64'd4, 0, 0, 0, 0, 1'b0);
    check("pc_wrap", pc, 64'h0);
    run(32'h0000_0013, 1'b0, 2'b00, 1'b0, 1'b0, tb_pc + 64'd4, 0, 0, 0, 0, 1'b0);

    // Load aborted by async reset while waiting for its response
    run(32'h0000_b183, 1'b1, 2'b01, 1'b0, 1'b0, tb_pc + 64'd4, 0, 0, 1, 0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_pc", pc, 64'h8000_0000);
    check("abort_ifu_req_valid", 64'(ifu_req_valid), 64'd1);
    check("abort_lsu_req_valid", 64'(lsu_req_valid), 64'd0);
    step();
    rst = 1'b0;
    tb_pc = 64'h8000_0000;
    lsu_rsp_valid = 1'b1;
    step(); step();
    lsu_rsp_valid = 1'b0;
    check("late_rsp_pc", pc, 64'h8000_0000);
    check("late_rsp_fetch", 64'(ifu_req_valid), 64'd1);

    // ADDI after reset, then EBREAK and spurious responses in HALT
    run(32'h0050_0093, 1'b1, 2'b00, 1'b0, 1'b0, tb_pc + 64'd4, 0, 0, 0, 0, 1'b0);
    run(32'h0010_0073, 1'b1, 2'b00, 1'b0, 1'b1, tb_pc + 64'd4, 0, 0, 0, 0, 1'b0);
    check("halt_set", 64'(halt), 64'd1);
    ifu_rsp_valid = 1'b1; ifu_req_ready = 1'b1; lsu_rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_no_ifu_req", 64'(ifu_req_valid), 64'd0);
    end
    ifu_rsp_valid = 1'b0; ifu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    check("halt_sticky", 64'(halt), 64'd1);
    check("halt_pc_frozen", pc, 64'h8000_0004);
    check("halt_inst", 64'(inst), 64'h0010_0073);
    step();
    check("retire_queue_empty", 64'(retire_q.size()), 64'd0);
    check("lsu_queue_empty", 64'(lsu_wen_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
